// File: rtl/stream_mux_n.sv
// stream_mux_n: N-channel registered stream multiplexer with valid/ready
// handshakes on every input and on the output. Grants follow either a fixed
// channel select or round-robin order starting after the last granted channel.
module stream_mux_n #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] rr_hi;
  logic [SEL_W-1:0] rr_lo;
  logic             hi_found;
  logic             lo_found;
  logic             grant_valid;
  logic             load;
  logic [WIDTH-1:0] grant_data;

  // Output register can take a word when empty or when it drains this cycle.
  assign load = !out_valid || out_ready;

  // Grant selection: fixed select, or round-robin split into two passes -
  // lowest valid channel above last_grant, else lowest valid channel overall
  // (the wrap-around case).
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    rr_hi       = '0;
    rr_lo       = '0;
    hi_found    = 1'b0;
    lo_found    = 1'b0;
    if (!mode) begin
      // A sel beyond the last channel never matches any index.
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant       = SEL_W'(i);
          grant_valid = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!hi_found && in_valid[i] && SEL_W'(i) > last_grant) begin
          rr_hi    = SEL_W'(i);
          hi_found = 1'b1;
        end
        if (!lo_found && in_valid[i]) begin
          rr_lo    = SEL_W'(i);
          lo_found = 1'b1;
        end
      end
      grant       = hi_found ? rr_hi : rr_lo;
      grant_valid = lo_found;
    end
  end

  // Per-channel ready and data of the granted channel.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = load && grant_valid;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      last_grant <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      if (grant_valid) begin
        out_valid  <= 1'b1;
        out_data   <= grant_data;
        out_chan   <= grant;
        last_grant <= grant;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_stream_mux_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] ch_data [4];
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  // Three-channel instance for the out-of-range select case.
  logic        mode3;
  logic [1:0]  sel3;
  logic [47:0] data3;
  logic [2:0]  valid3;
  logic [2:0]  ready3;
  logic [15:0] odata3;
  logic [1:0]  ochan3;
  logic        ovalid3;
  logic        oready3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  stream_mux_n #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  stream_mux_n #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
    .in_data(data3), .in_valid(valid3), .in_ready(ready3),
    .out_data(odata3), .out_chan(ochan3), .out_valid(ovalid3),
    .out_ready(oready3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  logic        model_ok = 1'b0;
  logic        m_valid, n_valid;
  logic [15:0] m_data, n_data;
  logic [1:0]  m_chan, n_chan;
  int          m_last, n_last;
  logic        n_ok = 1'b0;

  // Check outputs and ready against the model, then compute the model's next state.
  always @(negedge clk) begin
    int  g;
    bit  gv;
    bit  ld;
    logic [3:0] exp_ready;
    g  = 0;
    gv = 1'b0;
    if (mode == 1'b0) begin
      if (int'(sel) < 4 && in_valid[sel]) begin
        g  = int'(sel);
        gv = 1'b1;
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (!gv && in_valid[(m_last + k) % 4]) begin
          g  = (m_last + k) % 4;
          gv = 1'b1;
        end
      end
    end
    ld = !m_valid || out_ready;
    exp_ready = (ld && gv) ? (4'b0001 << g) : 4'b0000;
    if (model_ok) begin
      chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("model_out_data", {16'd0, out_data}, {16'd0, m_data});
      chk("model_out_chan", {30'd0, out_chan}, {30'd0, m_chan});
      chk("model_in_ready", {28'd0, in_ready}, {28'd0, exp_ready});
    end
    n_valid = m_valid; n_data = m_data; n_chan = m_chan; n_last = m_last;
    n_ok = model_ok;
    if (reset) begin
      n_valid = 1'b0; n_data = '0; n_chan = '0; n_last = 3; n_ok = 1'b1;
    end else if (ld) begin
      if (gv) begin
        n_valid = 1'b1; n_data = ch_data[g]; n_chan = 2'(g); n_last = g;
      end else begin
        n_valid = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    m_valid  = n_valid;
    m_data   = n_data;
    m_chan   = n_chan;
    m_last   = n_last;
    model_ok = n_ok;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) ch_data[i] = '0;
    mode3 = 1'b0; sel3 = '0; data3 = '0; valid3 = '0; oready3 = 1'b0;

    // Reset held two cycles.
    step();
    step();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {16'd0, out_data}, 32'd0);
    chk("reset_out_chan", {30'd0, out_chan}, 32'd0);
    chk("reset_in_ready", {28'd0, in_ready}, 32'd0);

    // Fixed select of channel 2 with every channel valid.
    reset = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
    ch_data[0] = 16'h1111; ch_data[1] = 16'h2222;
    ch_data[2] = 16'hBEEF; ch_data[3] = 16'h4444;
    #1;
    chk("fixed_in_ready", {28'd0, in_ready}, 32'h4);
    step();
    chk("fixed_out_valid", {31'd0, out_valid}, 32'd1);
    chk("fixed_out_data", {16'd0, out_data}, 32'hBEEF);
    chk("fixed_out_chan", {30'd0, out_chan}, 32'd2);

    // Backpressure for five cycles while sources change.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 4; i++) ch_data[i] = 16'($urandom);
      in_valid = 4'($urandom);
      #1;
      chk("hold_in_ready", {28'd0, in_ready}, 32'd0);
      step();
      chk("hold_out_data", {16'd0, out_data}, 32'hBEEF);
      chk("hold_out_chan", {30'd0, out_chan}, 32'd2);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1; in_valid = 4'hF; ch_data[2] = 16'h1234;
    #1;
    chk("release_in_ready", {28'd0, in_ready}, 32'h4);
    step();
    chk("release_out_data", {16'd0, out_data}, 32'h1234);

    // Reset while a word is held drops it.
    out_ready = 1'b0; reset = 1'b1;
    step();
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_out_data", {16'd0, out_data}, 32'd0);
    reset = 1'b0;

    // Round-robin, all channels valid, no backpressure.
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) ch_data[i] = 16'hA000 + 16'(i);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_out_valid", {31'd0, out_valid}, 32'd1);
      chk("rr_out_chan", {30'd0, out_chan}, 32'(k % 4));
      chk("rr_out_data", {16'd0, out_data}, 32'hA000 + 32'(k % 4));
    end

    // Wrap-around with only channels 3 and 1 valid, after a grant on 3.
    in_valid = 4'b1000;
    step();
    chk("wrap_pre_chan", {30'd0, out_chan}, 32'd3);
    in_valid = 4'b1010;
    step();
    chk("wrap_chan_a", {30'd0, out_chan}, 32'd1);
    step();
    chk("wrap_chan_b", {30'd0, out_chan}, 32'd3);
    step();
    chk("wrap_chan_c", {30'd0, out_chan}, 32'd1);

    // Three channels, select 3 out of range.
    mode3 = 1'b0; sel3 = 2'd3; valid3 = 3'b111; oready3 = 1'b1;
    data3 = {16'hC002, 16'hC001, 16'hC000};
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("oor_in_ready", {29'd0, ready3}, 32'd0);
      step();
      chk("oor_out_valid", {31'd0, ovalid3}, 32'd0);
    end
    sel3 = 2'd1;
    #1;
    chk("ch3_in_ready", {29'd0, ready3}, 32'h2);
    step();
    chk("ch3_out_valid", {31'd0, ovalid3}, 32'd1);
    chk("ch3_out_chan", {30'd0, ochan3}, 32'd1);
    chk("ch3_out_data", {16'd0, odata3}, 32'hC001);

    // Randomized run checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) ch_data[i] = 16'($urandom);
      step();
    end
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
